// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 iterations (accept at T, result at T+33; div-by-zero/overflow at T+1).
// Result is held with out_valid until out_ready; flush in BUSY/DONE drops it; start is taken only while idle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            in_ready,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;   // product accumulator, or partial remainder in the low word
  logic [2*XLEN-1:0] b_q;   // shifting multiplicand, or divisor in the low word
  logic [XLEN-1:0]   a_q;   // multiplier, or dividend shifting into quotient

  logic            accept, sgn1, sgn2, neg1, neg2, div0, ovf, special;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    accept      = (state == IDLE) && start && !flush;
    sgn1        = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn2        = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg1        = sgn1 && in1[XLEN-1];
    neg2        = sgn2 && in2[XLEN-1];
    mag1        = neg1 ? -in1 : in1;
    mag2        = neg2 ? -in2 : in2;
    div0        = op[2] && (in2 == '0);
    ovf         = op[2] && !op[0] && (in1 == MIN_INT) && (in2 == '1);
    special     = div0 || ovf;
    special_res = '0;
    if (div0) special_res = op[1] ? in1 : '1;
    else      special_res = op[1] ? '0 : MIN_INT;
  end

  logic [XLEN:0]     rem_sh, diff;
  logic              qbit;
  logic [2*XLEN-1:0] acc_nxt, b_nxt, prod;
  logic [XLEN-1:0]   a_nxt, qr, qr_fix, res_fin;
  logic [CW-1:0]     cnt_nxt;

  always_comb begin
    rem_sh = {acc[XLEN-1:0], a_q[XLEN-1]};
    diff   = rem_sh - {1'b0, b_q[XLEN-1:0]};
    qbit   = ~diff[XLEN];
    if (op_q[2]) begin
      acc_nxt = {{XLEN{1'b0}}, (qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0])};
      a_nxt   = {a_q[XLEN-2:0], qbit};
      b_nxt   = b_q;
    end else begin
      acc_nxt = a_q[0] ? acc + b_q : acc;
      a_nxt   = a_q >> 1;
      b_nxt   = b_q << 1;
    end
    // Sign fixup uses this cycle's iteration so the last step lands directly in result
    prod    = neg_q ? -acc_nxt : acc_nxt;
    qr      = op_q[1] ? acc_nxt[XLEN-1:0] : a_nxt;
    qr_fix  = neg_q ? -qr : qr;
    if (op_q[2])               res_fin = qr_fix;
    else if (op_q[1:0] == 2'b00) res_fin = prod[XLEN-1:0];
    else                       res_fin = prod[2*XLEN-1:XLEN];
    cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) state_nxt = special ? DONE : BUSY;
      end
      BUSY: begin
        if (flush)               state_nxt = IDLE;
        else if (cnt_nxt == '0)  state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      b_q    <= '0;
      a_q    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      neg_q <= (op == 3'b110) ? neg1 : (neg1 ^ neg2);
      cnt   <= CW'(XLEN);
      acc   <= '0;
      if (special) result <= special_res;
      if (op[2]) begin
        a_q <= mag1;
        b_q <= {{XLEN{1'b0}}, mag2};
      end else begin
        a_q <= mag2;
        b_q <= {{XLEN{1'b0}}, mag1};
      end
    end else if (state == BUSY && !flush) begin
      acc <= acc_nxt;
      a_q <= a_nxt;
      b_q <= b_nxt;
      cnt <= cnt_nxt;
      if (cnt_nxt == '0) result <= res_fin;
    end
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same two operands as the ALU, selected by the operand mux from ID/EX. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU using a radix-2 shift-add or restoring-divide datapath. Its result feeds the writeback result mux through a valid/ready handshake, and the hazard unit stalls issue while the unit is busy.

Parameters:
XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin an operation; accepted only when in_ready=1
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
in1  input  XLEN  operand rs1 (dividend / multiplicand)
in2  input  XLEN  operand rs2 (divisor / multiplier)
flush  input  1  pipeline kill; aborts any operation in progress
in_ready  output  1  unit idle and able to accept start
busy  output  1  operation in progress (BUSY or DONE state)
out_valid  output  1  result holds a completed result
out_ready  input  1  writeback consumes the result
result  output  XLEN  selected product half, quotient or remainder

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, busy=0, out_valid=0, result=0; all internal registers cleared. Reset asserted mid-operation discards the operation immediately.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. If start=1 and flush=0 in a cycle (T), the unit latches op and takes operand magnitudes (two's-complement negation where the operand is treated as signed and negative). It records the result-sign flags and a 6-bit counter=XLEN, then goes to BUSY. If start and flush are both high, start is not accepted.
- Special cases, detected at accept and going straight to DONE (out_valid=1 at T+1):
  - DIV/DIVU with in2=0: quotient=all-ones.
  - REM/REMU with in2=0: remainder=in1.
  - DIV with in1=0x80000000 and in2=0xFFFFFFFF: quotient=0x80000000.
  - REM with the same operands: remainder=0.
- BUSY: one iteration per cycle; the counter decrements; exit when the counter reaches 0 after the 32nd iteration.
  - Multiply: a 64-bit accumulator adds the shifted multiplicand when the multiplier LSB=1.
  - Divide: the partial remainder shifts left one bit, subtracts the divisor, and restores if negative; the quotient bit is shifted in.
  - On exit: apply the sign fixup, select the low word (MUL) or high word (MULH*), or the quotient/remainder, register it into result, then go to DONE.
  - Normal latency: accept at T, out_valid=1 at T+33.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: in1 signed, in2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - DIV quotient sign = sign(in1) XOR sign(in2).
  - REM remainder sign = sign(in1).
  - MUL low word is identical for signed and unsigned operands.
- DONE: out_valid=1 and result stable until the cycle with out_ready=1, then return to IDLE (in_ready=1 next cycle). There is no back-to-back accept in the same cycle as the consume.
- flush=1 in BUSY or DONE: return to IDLE next cycle with out_valid=0; the result is not delivered. flush in IDLE has no effect.
- Operand changes on in1/in2/op after accept have no effect.
- in_ready = (state==IDLE). busy = (state!=IDLE).

Test Plan:
- MUL/MULHU: in1=0xFFFFFFFF, in2=0xFFFFFFFF, op=000 -> result=0x00000001 at T+33. Same operands with op=011 -> result=0xFFFFFFFE.
- MULH/MULHSU: in1=0xFFFFFFFE (-2), in2=0x00000003. op=001 -> result=0xFFFFFFFF. op=010 -> result=0xFFFFFFFF. op=011 -> result=0x00000002.
- DIV/REM signed: in1=0xFFFFFFF9 (-7), in2=0x00000002. op=100 -> result=0xFFFFFFFD (-3). op=110 -> result=0xFFFFFFFF (-1). op=101 -> result=0x7FFFFFFC.
- Special cases: in2=0, in1=0x12345678. op=100 -> 0xFFFFFFFF at T+1; op=110 -> 0x12345678 at T+1. in1=0x80000000, in2=0xFFFFFFFF: op=100 -> 0x80000000; op=110 -> 0x00000000.
- Handshake/backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable and in_ready=0. Pulse out_ready -> IDLE next cycle. A start asserted during BUSY is ignored.
- Flush/reset: flush at T+10 of a DIVU -> IDLE at T+11, no out_valid, and a new op is accepted correctly afterwards. Assert rst_n=0 asynchronously mid-BUSY -> outputs reach reset values without a clock edge.
